dllp_rx_decode: RTL and testbench

// Receive-side DLLP decoder feeding the transmit datalink stage. It parses DLLPs arriving from the PHY on AXIS.
// Ack/Nak DLLPs drive the ack/nack sequence interface of the retry manager.

---
 rtl/dllp_rx_decode.sv | 210 +++++++++++++++++++++
 tb/tb_dllp_rx_decode.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dllp_rx_decode.sv
// Receive DLLP decoder: Ack/Nak to retry manager, FC DLLPs to tx credit limits.
// Optional DLLP_CRC_CHECK_EN enables CRC16 checking of each DLLP.
//
// Ports:
//   clk_i, rst_ni            clock, async active-low reset
//   s_axis_dllp_*            AXIS DLLP input (2 beats per DLLP)
//   ack_nack_o/_vld_o        Ack(1)/Nak(0) and its 1-cycle strobe
//   ack_seq_num_o            AckNak sequence number
//   tx_fc_ph/pd/nph/npd_o    posted / non-posted credit limits
//   fc_init_done_o           sticky, InitFC2 P+NP+Cpl seen
//   dllp_err_cnt_o           saturating dropped-DLLP count
// Config macro: DLLP_CRC_CHECK_EN (undefined = CRC bytes ignored).
module dllp_rx_decode #(
  parameter int DATA_WIDTH = 32,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int VC_ID      = 0
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [DATA_WIDTH-1:0] s_axis_dllp_tdata_i,
  input  logic [KEEP_WIDTH-1:0] s_axis_dllp_tkeep_i,
  input  logic                  s_axis_dllp_tvalid_i,
  input  logic                  s_axis_dllp_tlast_i,
  output logic                  s_axis_dllp_tready_o,
  output logic                  ack_nack_o,
  output logic                  ack_nack_vld_o,
  output logic [11:0]           ack_seq_num_o,
  output logic [7:0]            tx_fc_ph_o,
  output logic [11:0]           tx_fc_pd_o,
  output logic [7:0]            tx_fc_nph_o,
  output logic [11:0]           tx_fc_npd_o,
  output logic                  fc_init_done_o,
  output logic [7:0]            dllp_err_cnt_o
);

  if (DATA_WIDTH != 32) begin : g_bad_width
    $error("dllp_rx_decode: only DATA_WIDTH=32 is supported");
  end

  localparam logic [2:0] VC = 3'(VC_ID);

  typedef enum logic [1:0] {
    BEAT0 = 2'd0,
    BEAT1 = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic        hs;
  logic        cap_en;
  logic        fin;
  logic        frm_err;
  logic [31:0] cap_q;
  logic [7:0]  b0, b1, b2, b3;
  logic [3:0]  nib;
  logic        is_ack, is_nak;
  logic        fc_p, fc_np, fc_cpl, fc_any, init2;
  logic        known;
  logic        crc_ok;
  logic        commit;
  logic        drop;
  logic        fc_hit;
  logic [7:0]  hdr_fc;
  logic [11:0] data_fc;
  logic [2:0]  seen_q;
  logic        unused_bits;

  // DLLPs are never back-pressured; ready follows reset directly.
  assign s_axis_dllp_tready_o = rst_ni;
  assign hs = s_axis_dllp_tvalid_i & s_axis_dllp_tready_o;

  // Framing FSM: state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= BEAT0;
    else         state_q <= state_d;
  end

  // Framing FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      BEAT0: if (hs && !s_axis_dllp_tlast_i) state_d = BEAT1;
      BEAT1: begin
        if (hs) begin
          if (s_axis_dllp_tlast_i) state_d = BEAT0;
          else                     state_d = DRAIN;
        end
      end
      DRAIN: if (hs && s_axis_dllp_tlast_i) state_d = BEAT0;
      default: state_d = BEAT0;
    endcase
  end

  // Framing FSM: outputs
  always_comb begin
    cap_en  = 1'b0;
    fin     = 1'b0;
    frm_err = 1'b0;
    unique case (state_q)
      BEAT0: begin
        if (hs) begin
          if (s_axis_dllp_tlast_i) frm_err = 1'b1;
          else                     cap_en  = 1'b1;
        end
      end
      BEAT1: begin
        if (hs) begin
          if (s_axis_dllp_tlast_i) fin     = 1'b1;
          else                     frm_err = 1'b1;
        end
      end
      DRAIN: ;
      default: ;
    endcase
  end

  assign b0 = cap_q[7:0];
  assign b1 = cap_q[15:8];
  assign b2 = cap_q[23:16];
  assign b3 = cap_q[31:24];
  assign nib = b0[7:4];

  assign is_ack = (b0 == 8'h00);
  assign is_nak = (b0 == 8'h10);
  assign fc_p   = !b0[3] && (nib == 4'h4 || nib == 4'hC || nib == 4'h8);
  assign fc_np  = !b0[3] && (nib == 4'h5 || nib == 4'hD || nib == 4'h9);
  assign fc_cpl = !b0[3] && (nib == 4'h6 || nib == 4'hE || nib == 4'hA);
  assign fc_any = fc_p | fc_np | fc_cpl;
  assign init2  = (nib[3:2] == 2'b11);
  assign known  = is_ack | is_nak | fc_any;

  assign hdr_fc  = {b1[5:0], b2[7:6]};
  assign data_fc = {b2[3:0], b3};

`ifdef DLLP_CRC_CHECK_EN
  function automatic logic [15:0] crc16_dllp(input logic [31:0] d);
    logic [15:0] c;
    logic        fb;
    c = 16'hFFFF;
    // Byte 0 first, each byte LSB first.
    for (int i = 0; i < 32; i++) begin
      fb = c[15] ^ d[i];
      c  = {c[14:0], 1'b0};
      if (fb) c = c ^ 16'h100B;
    end
    return ~c;
  endfunction

  function automatic logic [7:0] rev8(input logic [7:0] x);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = x[7-i];
    return r;
  endfunction

  logic [15:0] crc_calc;
  assign crc_calc = crc16_dllp(cap_q);
  assign crc_ok =
    (s_axis_dllp_tdata_i[7:0]  == rev8(crc_calc[15:8])) &&
    (s_axis_dllp_tdata_i[15:8] == rev8(crc_calc[7:0]));
`else
  assign crc_ok = 1'b1;
`endif

  assign commit = fin & crc_ok & known;
  assign drop   = frm_err | (fin & ~(crc_ok & known));
  // Foreign-VC FC DLLPs fall out here silently.
  assign fc_hit = commit & fc_any & (b0[2:0] == VC);

  assign unused_bits = ^{s_axis_dllp_tkeep_i, b1[7:6], b2[5:4]};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cap_q          <= '0;
      ack_nack_o     <= 1'b0;
      ack_nack_vld_o <= 1'b0;
      ack_seq_num_o  <= '0;
      tx_fc_ph_o     <= '0;
      tx_fc_pd_o     <= '0;
      tx_fc_nph_o    <= '0;
      tx_fc_npd_o    <= '0;
      seen_q         <= '0;
      dllp_err_cnt_o <= '0;
    end else begin
      if (cap_en) cap_q <= s_axis_dllp_tdata_i[31:0];
      ack_nack_vld_o <= commit & (is_ack | is_nak);
      if (commit && (is_ack || is_nak)) begin
        ack_nack_o    <= is_ack;
        ack_seq_num_o <= data_fc;
      end
      if (fc_hit && fc_p) begin
        tx_fc_ph_o <= hdr_fc;
        tx_fc_pd_o <= data_fc;
      end
      if (fc_hit && fc_np) begin
        tx_fc_nph_o <= hdr_fc;
        tx_fc_npd_o <= data_fc;
      end
      if (fc_hit && init2) begin
        seen_q <= seen_q | {fc_cpl, fc_np, fc_p};
      end
      if (drop && dllp_err_cnt_o != 8'hFF) begin
        dllp_err_cnt_o <= dllp_err_cnt_o + 8'd1;
      end
    end
  end

  assign fc_init_done_o = &seen_q;

endmodule

// File: tb/tb_dllp_rx_decode.sv
// Testbench for dllp_rx_decode: scoreboarded Ack/Nak strobes plus
// inline credit, error-count and reset checks.
module tb_dllp_rx_decode;

  logic        clk;
  logic        rst_n;
  logic [31:0] tdata;
  logic [3:0]  tkeep;
  logic        tvalid;
  logic        tlast;
  logic        tready;
  logic        ack_nack_o;
  logic        ack_nack_vld_o;
  logic [11:0] ack_seq_num_o;
  logic [7:0]  tx_fc_ph_o;
  logic [11:0] tx_fc_pd_o;
  logic [7:0]  tx_fc_nph_o;
  logic [11:0] tx_fc_npd_o;
  logic        fc_init_done_o;
  logic [7:0]  dllp_err_cnt_o;

  dllp_rx_decode #(.DATA_WIDTH(32), .VC_ID(0)) dut (
    .clk_i                (clk),
    .rst_ni               (rst_n),
    .s_axis_dllp_tdata_i  (tdata),
    .s_axis_dllp_tkeep_i  (tkeep),
    .s_axis_dllp_tvalid_i (tvalid),
    .s_axis_dllp_tlast_i  (tlast),
    .s_axis_dllp_tready_o (tready),
    .ack_nack_o           (ack_nack_o),
    .ack_nack_vld_o       (ack_nack_vld_o),
    .ack_seq_num_o        (ack_seq_num_o),
    .tx_fc_ph_o           (tx_fc_ph_o),
    .tx_fc_pd_o           (tx_fc_pd_o),
    .tx_fc_nph_o          (tx_fc_nph_o),
    .tx_fc_npd_o          (tx_fc_npd_o),
    .fc_init_done_o       (fc_init_done_o),
    .dllp_err_cnt_o       (dllp_err_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        ack;
    logic [11:0] seq;
  } exp_t;

  exp_t exp_q[$];
  int   strobe_cyc[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   exp_err = 0;

  // Scoreboard: every Ack/Nak strobe must match the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (rst_n && ack_nack_vld_o) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL strobe_unexpected got ack=%0b seq=%h want none",
                 ack_nack_o, ack_seq_num_o);
      end else begin
        e = exp_q.pop_front();
        strobe_cyc.push_back(cyc);
        if ({ack_nack_o, ack_seq_num_o} !== {e.ack, e.seq}) begin
          errors++;
          $display("FAIL strobe_value got ack=%0b seq=%h want ack=%0b seq=%h",
                   ack_nack_o, ack_seq_num_o, e.ack, e.seq);
        end
      end
    end
  end

  function automatic logic [7:0] rev8(input logic [7:0] x);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = x[7-i];
    return r;
  endfunction

  // Returns {byte4, byte5} for a DLLP body.
  function automatic logic [15:0] tb_crc(input logic [31:0] w);
    logic [15:0] lfsr;
    logic [7:0]  by;
    logic        fb;
    lfsr = 16'hFFFF;
    for (int k = 0; k < 4; k++) begin
      by = w[8*k +: 8];
      for (int j = 0; j < 8; j++) begin
        fb   = lfsr[15] ^ by[j];
        lfsr = {lfsr[14:0], 1'b0};
        if (fb) lfsr = lfsr ^ 16'h100B;
      end
    end
    lfsr = ~lfsr;
    return {rev8(lfsr[15:8]), rev8(lfsr[7:0])};
  endfunction

  task automatic beat(input logic [31:0] d, input logic [3:0] k,
                      input logic l);
    @(negedge clk);
    tdata  = d;
    tkeep  = k;
    tlast  = l;
    tvalid = 1'b1;
  endtask

  task automatic idle();
    @(negedge clk);
    tvalid = 1'b0;
    tlast  = 1'b0;
  endtask

  task automatic send(input logic [7:0] b0, input logic [7:0] b1,
                      input logic [7:0] b2, input logic [7:0] b3,
                      input logic bad);
    logic [31:0] w;
    logic [15:0] c;
    w = {b3, b2, b1, b0};
    c = tb_crc(w);
    if (bad) c[0] = ~c[0];
    beat(w, 4'hF, 1'b0);
    beat({16'h0, c[7:0], c[15:8]}, 4'h3, 1'b1);
  endtask

  task automatic send_fc(input logic [7:0] ty, input logic [7:0] hdr,
                         input logic [11:0] dat);
    send(ty, {2'b00, hdr[7:2]}, {hdr[1:0], 2'b00, dat[11:8]},
         dat[7:0], 1'b0);
  endtask

  task automatic send_acknak(input logic ack, input logic [11:0] seq);
    exp_q.push_back('{ack: ack, seq: seq});
    send(ack ? 8'h00 : 8'h10, 8'h00, {4'h0, seq[11:8]}, seq[7:0], 1'b0);
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 8 && exp_q.size() != 0; i++) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain got %0d pending strobes want 0",
               name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_err(input string name);
    checks++;
    if (dllp_err_cnt_o !== 8'(exp_err)) begin
      errors++;
      $display("FAIL %s_errcnt got %0d want %0d", name, dllp_err_cnt_o,
               exp_err);
    end
  endtask

  task automatic check_credits(input string name, input logic [7:0] ph,
                               input logic [11:0] pd, input logic [7:0] nph,
                               input logic [11:0] npd);
    checks++;
    if ({tx_fc_ph_o, tx_fc_pd_o, tx_fc_nph_o, tx_fc_npd_o} !==
        {ph, pd, nph, npd}) begin
      errors++;
      $display("FAIL %s_credits got %h/%h/%h/%h want %h/%h/%h/%h", name,
               tx_fc_ph_o, tx_fc_pd_o, tx_fc_nph_o, tx_fc_npd_o,
               ph, pd, nph, npd);
    end
  endtask

  task automatic check_zero(input string name);
    checks++;
    if ({ack_nack_o, ack_nack_vld_o, ack_seq_num_o, tx_fc_ph_o, tx_fc_pd_o,
         tx_fc_nph_o, tx_fc_npd_o, fc_init_done_o, dllp_err_cnt_o} !== '0)
    begin
      errors++;
      $display("FAIL %s_outputs got nonzero outputs want all 0", name);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (tready !== 1'b0) begin
      errors++;
      $display("FAIL reset_tready got %0b want 0", tready);
    end
    check_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (tready !== 1'b1) begin
      errors++;
      $display("FAIL run_tready got %0b want 1", tready);
    end
    check_zero("after_reset");
  endtask

  task automatic test_ack();
    exp_q.push_back('{ack: 1'b1, seq: 12'h234});
    send(8'h00, 8'h00, 8'h12, 8'h34, 1'b0);
    idle();
    checks++;
    if (ack_nack_vld_o !== 1'b1) begin
      errors++;
      $display("FAIL ack_latency got vld=%0b want 1", ack_nack_vld_o);
    end
    @(negedge clk);
    checks++;
    if (ack_nack_vld_o !== 1'b0) begin
      errors++;
      $display("FAIL ack_width got vld=%0b want 0", ack_nack_vld_o);
    end
    wait_drain("ack");
  endtask

  task automatic test_back_to_back();
    strobe_cyc.delete();
    send_acknak(1'b0, 12'hFFF);
    send_acknak(1'b1, 12'h001);
    idle();
    repeat (3) @(negedge clk);
    wait_drain("b2b");
    checks++;
    if (strobe_cyc.size() != 2) begin
      errors++;
      $display("FAIL b2b_count got %0d want 2", strobe_cyc.size());
    end else if (strobe_cyc[1] - strobe_cyc[0] != 2) begin
      errors++;
      $display("FAIL b2b_spacing got %0d want 2",
               strobe_cyc[1] - strobe_cyc[0]);
    end
  endtask

  task automatic test_fc_init();
    send_fc(8'hC0, 8'h20, 12'h080);
    idle();
    checks++;
    if (fc_init_done_o !== 1'b0) begin
      errors++;
      $display("FAIL fc_done_p got %0b want 0", fc_init_done_o);
    end
    send_fc(8'hD0, 8'h01, 12'h001);
    idle();
    checks++;
    if (fc_init_done_o !== 1'b0) begin
      errors++;
      $display("FAIL fc_done_np got %0b want 0", fc_init_done_o);
    end
    send_fc(8'hE0, 8'h77, 12'h777);
    idle();
    checks++;
    if (fc_init_done_o !== 1'b1) begin
      errors++;
      $display("FAIL fc_done_cpl got %0b want 1", fc_init_done_o);
    end
    check_credits("fc_init", 8'h20, 12'h080, 8'h01, 12'h001);
    check_err("fc_init");
  endtask

  task automatic test_fc_update();
    send_fc(8'h81, 8'h55, 12'h555);
    idle();
    check_credits("foreign_vc", 8'h20, 12'h080, 8'h01, 12'h001);
    check_err("foreign_vc");
    send_fc(8'h80, 8'h10, 12'h040);
    idle();
    check_credits("update_p", 8'h10, 12'h040, 8'h01, 12'h001);
    send_fc(8'h50, 8'hAB, 12'hCDE);
    idle();
    check_credits("initfc1_np", 8'h10, 12'h040, 8'hAB, 12'hCDE);
    send(8'h30, 8'h00, 8'h00, 8'h00, 1'b0);
    idle();
    exp_err++;
    check_err("unknown_type");
    send(8'h01, 8'h00, 8'h01, 8'h23, 1'b0);
    idle();
    exp_err++;
    check_err("ack_vc_bits");
    repeat (2) @(negedge clk);
    wait_drain("fc_update");
  endtask

  task automatic test_malformed();
    beat(32'h0000_0000, 4'hF, 1'b0);
    beat(32'h0000_0000, 4'h3, 1'b0);
    idle();
    beat(32'hDEAD_BEEF, 4'h3, 1'b1);
    idle();
    exp_err++;
    check_err("three_beat");
    send_acknak(1'b1, 12'h5A5);
    idle();
    beat(32'h0000_0000, 4'hF, 1'b1);
    idle();
    exp_err++;
    check_err("short_dllp");
    exp_q.push_back('{ack: 1'b0, seq: 12'h3C3});
    beat({8'hC3, 8'h03, 8'h00, 8'h10}, 4'hF, 1'b0);
    idle();
    idle();
    beat({16'h0, tb_crc({8'hC3, 8'h03, 8'h00, 8'h10})}, 4'h3, 1'b0);
    tdata = {16'h0, tb_crc({8'hC3, 8'h03, 8'h00, 8'h10})[7:0],
             tb_crc({8'hC3, 8'h03, 8'h00, 8'h10})[15:8]};
    tlast = 1'b1;
    idle();
    wait_drain("malformed");
    check_err("gapped_nak");
  endtask

  task automatic test_crc();
`ifdef DLLP_CRC_CHECK_EN
    send(8'h00, 8'h00, 8'h04, 8'h56, 1'b1);
    idle();
    exp_err++;
    repeat (2) @(negedge clk);
    check_err("bad_crc");
`else
    exp_q.push_back('{ack: 1'b1, seq: 12'h456});
    send(8'h00, 8'h00, 8'h04, 8'h56, 1'b1);
    idle();
    wait_drain("crc_ignored");
    check_err("crc_ignored");
`endif
  endtask

  task automatic test_mid_reset();
    beat({8'h99, 8'h09, 8'h00, 8'h00}, 4'hF, 1'b0);
    @(negedge clk);
    tvalid = 1'b0;
    rst_n = 1'b0;
    #1;
    check_zero("mid_reset");
    @(negedge clk);
    rst_n = 1'b1;
    exp_err = 0;
    repeat (3) @(negedge clk);
    check_zero("post_mid_reset");
    send_acknak(1'b1, 12'h777);
    idle();
    wait_drain("post_reset_ack");
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 260; i++) begin
      send(8'h30, 8'h00, 8'h00, 8'h00, 1'b0);
      if (i == 253) begin
        idle();
        exp_err = 254;
        check_err("sat_pre");
      end
    end
    idle();
    exp_err = 255;
    check_err("saturate");
  endtask

  initial begin
    tdata  = '0;
    tkeep  = '0;
    tvalid = 1'b0;
    tlast  = 1'b0;
    rst_n  = 1'b0;
    test_reset();
    test_ack();
    test_back_to_back();
    test_fc_init();
    test_fc_update();
    test_malformed();
    test_crc();
    test_mid_reset();
    test_saturate();
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
